ram_banked_clr: RTL and testbench



---
 rtl/ram_banked_clr.sv | 152 +++++++++++++++
 tb/tb_ram_banked_clr.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ram_banked_clr.sv
// ram_banked_clr: banked single-port RAM with a registered read port and a
// bank-parallel clear engine launched by reset or by a clear request.
// Optional per-word parity storage and checking is enabled with the
// PARITY_EN macro; without it perr is constant 0 and perr_inj has no effect.
module ram_banked_clr #(
  parameter int                WIDTH   = 16,
  parameter int                ADDR_W  = 12,
  parameter int                BANK_W  = 3,
  parameter logic [WIDTH-1:0]  CLR_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] add,
  input  logic              load,
  input  logic              clr,
  input  logic              perr_inj,
  output logic [WIDTH-1:0]  o,
  output logic              busy,
  output logic              done,
  output logic              perr
);

  localparam int OFF_W = ADDR_W - BANK_W;
  localparam int NBANK = 1 << BANK_W;
  localparam int NWORD = 1 << OFF_W;
  localparam logic [OFF_W-1:0] PTR_LAST = {OFF_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   o_q, o_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;

  logic [BANK_W-1:0]  bank_sel_s;
  logic [OFF_W-1:0]   off_s;
  logic [WIDTH-1:0]   rd_data_s [NBANK];
`ifdef PARITY_EN
  logic               rd_par_s  [NBANK];
`endif

  assign bank_sel_s = add[ADDR_W-1:OFF_W];
  assign off_s      = add[OFF_W-1:0];

  genvar b;
  generate
    for (b = 0; b < NBANK; b++) begin : g_bank
      logic [WIDTH-1:0] bank_mem_q [NWORD];

      // Bank storage: sweep writes CLR_VAL at ptr in every bank; in IDLE only the addressed bank takes a load
      always_ff @(posedge clk) begin
        if (!rst && state_q == S_CLEAR) begin
          bank_mem_q[ptr_q] <= CLR_VAL;
        end else if (!rst && state_q == S_IDLE && load && bank_sel_s == BANK_W'(b)) begin
          bank_mem_q[off_s] <= in;
        end
      end

      assign rd_data_s[b] = bank_mem_q[off_s];

`ifdef PARITY_EN
      logic bank_par_q [NWORD];

      // Parity storage: cleared words get the parity of CLR_VAL, loads may carry an injected error
      always_ff @(posedge clk) begin
        if (!rst && state_q == S_CLEAR) begin
          bank_par_q[ptr_q] <= ^CLR_VAL;
        end else if (!rst && state_q == S_IDLE && load && bank_sel_s == BANK_W'(b)) begin
          bank_par_q[off_s] <= (^in) ^ perr_inj;
        end
      end

      assign rd_par_s[b] = bank_par_q[off_s];
`endif
    end
  endgenerate

  // Next-state logic: clear sweep sequencing, IDLE reads and clear launch
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    o_d     = o_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    case (state_q)
      S_CLEAR: begin
        // Outputs hold; load and clr are ignored until the sweep ends
        ptr_d = ptr_q + OFF_W'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      S_IDLE: begin
        // Read-before-write: o takes the contents present before this edge's load
        o_d = rd_data_s[bank_sel_s];
`ifdef PARITY_EN
        perr_d = (^rd_data_s[bank_sel_s]) != rd_par_s[bank_sel_s];
`else
        perr_d = perr_inj & 1'b0;
`endif
        if (clr) begin
          state_d = S_CLEAR;
          busy_d  = 1'b1;
          ptr_d   = {OFF_W{1'b0}};
        end else begin
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        busy_d  = 1'b1;
        ptr_d   = {OFF_W{1'b0}};
      end
    endcase
  end

  // Control and output registers; reset launches a fresh clear sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= {OFF_W{1'b0}};
      o_q     <= {WIDTH{1'b0}};
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  assign o    = o_q;
  assign busy = busy_q;
  assign done = done_q;
  assign perr = perr_q;

endmodule

// File: tb/tb_ram_banked_clr.sv
// Self-checking bench for ram_banked_clr (WIDTH=8, ADDR_W=4, BANK_W=2,
// CLR_VAL=8'hA5). Expected read data is pushed to a scoreboard queue when a
// read is driven and popped when the registered output becomes valid.
module tb_ram_banked_clr;

  localparam int         WIDTH  = 8;
  localparam int         ADDR_W = 4;
  localparam int         BANK_W = 2;
  localparam logic [7:0] CV     = 8'hA5;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] add;
  logic              load;
  logic              clr;
  logic              perr_inj;
  logic [WIDTH-1:0]  o;
  logic              busy;
  logic              done;
  logic              perr;

  ram_banked_clr #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .BANK_W  (BANK_W),
    .CLR_VAL (CV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .add      (add),
    .load     (load),
    .clr      (clr),
    .perr_inj (perr_inj),
    .o        (o),
    .busy     (busy),
    .done     (done),
    .perr     (perr)
  );

  typedef struct {
    logic [7:0] exp_o;
    logic       exp_pe;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] model_mem  [16];
  logic       model_perr [16];
  int         n_vec;
  int         n_err;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      model_mem[i]  = CV;
      model_perr[i] = 1'b0;
    end
  endtask

  // One IDLE cycle: read add (expected value queued), optional load/clr
  task automatic rw(input string tag, input logic [3:0] a, input logic [7:0] d,
                    input logic ld, input logic inj, input logic cl);
    exp_t e;
    e.exp_o = model_mem[a];
`ifdef PARITY_EN
    e.exp_pe = model_perr[a];
`else
    e.exp_pe = 1'b0;
`endif
    sb_q.push_back(e);
    if (ld) begin
      model_mem[a]  = d;
      model_perr[a] = inj;
    end
    add = a; in = d; load = ld; perr_inj = inj; clr = cl;
    @(posedge clk); #1;
    load = 1'b0; clr = 1'b0; perr_inj = 1'b0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, "_o"}, 32'(o), 32'(e.exp_o));
      check_val({tag, "_perr"}, 32'(perr), 32'(e.exp_pe));
    end else begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end
  endtask

  // Run a sweep to completion with given inputs held; o must hold hold_o
  task automatic wait_clear(input string tag, input logic ld, input logic cl,
                            input logic [7:0] d, input logic [3:0] a, input logic [7:0] hold_o);
    int cnt;
    load = ld; clr = cl; in = d; add = a;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      check_val({tag, "_hold_o"}, 32'(o), 32'(hold_o));
    end while (busy && cnt < 10);
    check_val({tag, "_busy_edges"}, 32'(cnt), 32'd4);
    check_val({tag, "_done_hi"}, 32'(done), 32'd1);
    load = 1'b0; clr = 1'b0; in = 8'h00; add = 4'h0;
    @(posedge clk); #1;
    check_val({tag, "_done_lo"}, 32'(done), 32'd0);
    check_val({tag, "_busy_lo"}, 32'(busy), 32'd0);
    model_clear();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clk = 1'b0; rst = 1'b1;
    in = 8'h00; add = 4'h0; load = 1'b0; clr = 1'b0; perr_inj = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_o",    32'(o),    32'd0);
    check_val("rst_busy", 32'(busy), 32'd1);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_perr", 32'(perr), 32'd0);

    // 1. Power-up clear and full read-back
    rst = 1'b0;
    wait_clear("pwrup", 1'b0, 1'b0, 8'h00, 4'h0, 8'h00);
    for (int a = 0; a < 16; a++) rw("clr_rd", 4'(a), 8'h00, 1'b0, 1'b0, 1'b0);

    // 2. Bank isolation
    rw("wr3", 4'h3, 8'h11, 1'b1, 1'b0, 1'b0);
    rw("wr7", 4'h7, 8'h22, 1'b1, 1'b0, 1'b0);
    rw("rd3", 4'h3, 8'h00, 1'b0, 1'b0, 1'b0);
    rw("rd7", 4'h7, 8'h00, 1'b0, 1'b0, 1'b0);
    rw("rdB", 4'hB, 8'h00, 1'b0, 1'b0, 1'b0);
    rw("rdF", 4'hF, 8'h00, 1'b0, 1'b0, 1'b0);

    // 3. Read-before-write
    rw("wr5",  4'h5, 8'h33, 1'b1, 1'b0, 1'b0);
    rw("rbw5", 4'h5, 8'h44, 1'b1, 1'b0, 1'b0);
    rw("rd5",  4'h5, 8'h00, 1'b0, 1'b0, 1'b0);

    // 4. Busy lockout: load and repeated clr during the sweep are ignored
    rw("wr2",  4'h2, 8'h5A, 1'b1, 1'b0, 1'b0);
    rw("clr2", 4'h2, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("clr_busy", 32'(busy), 32'd1);
    wait_clear("lock", 1'b1, 1'b1, 8'hFF, 4'h2, 8'h5A);
    rw("rd2", 4'h2, 8'h00, 1'b0, 1'b0, 1'b0);

    // 5. Reset in the middle of a sweep restarts it
    rw("wr6",   4'h6, 8'h66, 1'b1, 1'b0, 1'b0);
    rw("clr6",  4'h6, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_val("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_o",    32'(o),    32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clear("midrst", 1'b0, 1'b0, 8'h00, 4'h0, 8'h00);
    rw("rd6", 4'h6, 8'h00, 1'b0, 1'b0, 1'b0);

    // 6. Parity injection (perr expectation follows the build)
    rw("wr9", 4'h9, 8'h0F, 1'b1, 1'b1, 1'b0);
    rw("rd9", 4'h9, 8'h00, 1'b0, 1'b0, 1'b0);
    rw("rd0", 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    rw("wrA", 4'hA, 8'h07, 1'b1, 1'b0, 1'b0);
    rw("rdA", 4'hA, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
